// File: rtl/pio_pkg.sv
// Shared constants for the input PIO: register word addresses and edge-capture mode encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pio_pkg;

  // Avalon-MM word addresses of the register map
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // EDGE_TYPE parameter encodings
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Synchronises a WIDTH-bit asynchronous input bus and flags per-bit edges of the selected type.
// Latency: sync_o follows in_i after SYNC_STAGES edges; edge_o is high for the cycle after sync_o changes.
// Backpressure: none; free-running every clock.
//
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   in_i          raw asynchronous inputs
//   sync_o        synchronised inputs (last stage of the chain)
//   edge_o        one-cycle detect pulse per bit
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

  // Detect compares the synchronised value against its one-cycle-old copy,
  // so each transition produces exactly one pulse.
  generate
    if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
      assign edge_o = ~sync_o & prev_q;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_o = sync_o ^ prev_q;
    end else begin : g_rise
      assign edge_o = sync_o & ~prev_q;
    end
  endgenerate

endmodule

// File: rtl/pio_input_edge_capture.sv
// Avalon-MM input PIO: synchronised DATA, IRQ_MASK, write-1-to-clear EDGE_CAPTURE and a level irq.
// Latency: readdata is registered, one cycle after address; irq is combinational from registers.
// Backpressure: none; zero wait states, every access completes.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   address, chipselect, write_n,
//   writedata                         Avalon-MM slave write side (word address)
//   readdata                          registered read data, bits above WIDTH zero
//   in_port                           external asynchronous inputs
//   irq                               |(EDGE_CAPTURE & IRQ_MASK)
module pio_input_edge_capture
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = EDGE_RISING,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] edge_pulse;

  logic [WIDTH-1:0] mask_q,     mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] rd_bits;

  // Upper writedata bits are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, writedata};

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_i    (in_port),
    .sync_o  (sync_val),
    .edge_o  (edge_pulse)
  );

  always_comb begin
    wr_en = chipselect & ~write_n;

    mask_d = mask_q;
    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end

    clr_bits = '0;
    if (wr_en && (address == ADDR_EDGE)) begin
      clr_bits = writedata[WIDTH-1:0];
    end

    // OR-ing the detect in after the clear makes a new edge win over a
    // simultaneous software clear, so no event is lost.
    edge_cap_d = (edge_cap_q & ~clr_bits) | edge_pulse;

    // Read mux uses the pre-write register state; a write shows up one edge later.
    rd_bits = '0;
    case (address)
      ADDR_DATA: rd_bits = sync_val;
      ADDR_DIR:  rd_bits = '0;
      ADDR_MASK: rd_bits = mask_q;
      ADDR_EDGE: rd_bits = edge_cap_q;
      default:   rd_bits = '0;
    endcase

    readdata_d = '0;
    readdata_d[WIDTH-1:0] = rd_bits;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & mask_q);

endmodule

// File: tb/tb_pio_input_edge_capture.sv
module tb_pio_input_edge_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;

  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: rising, 1: falling, 2: any edge; all share the bus and inputs.
  pio_input_edge_capture #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));

  pio_input_edge_capture #(.WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(2)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd1), .irq(irq1));

  pio_input_edge_capture #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  // Scoreboard queues: expected read data and expected irq levels.
  int          rd_sel_q[$];
  logic [31:0] rd_val_q[$];
  string       rd_nm_q[$];
  int          ir_sel_q[$];
  logic        ir_val_q[$];
  string       ir_nm_q[$];

  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  logic irq_req = 1'b0;

  // readdata is valid the cycle after the address was presented.
  always @(posedge clk) rd_vld <= rd_req;

  function automatic logic [31:0] pick_rd(int s);
    case (s)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  function automatic logic pick_irq(int s);
    case (s)
      0:       return irq0;
      1:       return irq1;
      default: return irq2;
    endcase
  endfunction

  // Monitor: pops the expected value whenever an output is presented.
  always @(negedge clk) begin : monitor
    int          s;
    logic [31:0] ev;
    logic        ei;
    string       nm;
    if (rd_vld) begin
      if (rd_val_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: no expected value queued, readdata=%08h", rd0);
      end else begin
        s  = rd_sel_q.pop_front();
        ev = rd_val_q.pop_front();
        nm = rd_nm_q.pop_front();
        checks++;
        if (pick_rd(s) !== ev) begin
          errors++;
          $display("FAIL %s: readdata(dut%0d) got %08h expected %08h", nm, s, pick_rd(s), ev);
        end
      end
    end
    if (irq_req) begin
      if (ir_val_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_irq_sample: no expected value queued");
      end else begin
        s  = ir_sel_q.pop_front();
        ei = ir_val_q.pop_front();
        nm = ir_nm_q.pop_front();
        checks++;
        if (pick_irq(s) !== ei) begin
          errors++;
          $display("FAIL %s: irq(dut%0d) got %0b expected %0b", nm, s, pick_irq(s), ei);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input int s, input logic [1:0] a, input logic [31:0] e, input string nm);
    rd_sel_q.push_back(s);
    rd_val_q.push_back(e);
    rd_nm_q.push_back(nm);
    address = a;
    rd_req  = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  // Samples irq in the current cycle (before the next rising edge).
  task automatic ci(input int s, input logic e, input string nm);
    ir_sel_q.push_back(s);
    ir_val_q.push_back(e);
    ir_nm_q.push_back(nm);
    irq_req = 1'b1;
    @(negedge clk);
    #1;
    irq_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset_n    = 1'b0;
    in_port    = 8'hA5;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    tick(3);
    check("rst_readdata", rd0, 32'h0);
    check("rst_irq", {31'b0, irq0}, 32'h0);

    // Steady A5 through reset: seen as rising edges after release.
    reset_n = 1'b1;
    tick(5);
    rd(0, 2'd0, 32'h0000_00A5, "data_a5");
    rd(0, 2'd3, 32'h0000_00A5, "edge_a5_after_reset");
    rd(0, 2'd1, 32'h0, "dir_reads_zero");
    wr(2'd3, 32'hFF);
    rd(0, 2'd3, 32'h0, "edge_cleared");

    // Bit0 rising with mask 01: capture and irq two edges after input change.
    in_port = 8'hA4;
    tick(4);
    wr(2'd2, 32'h01);
    in_port = 8'hA5;
    tick(2);
    ci(0, 1'b0, "irq_edge_k1");
    ci(0, 1'b1, "irq_edge_k2");
    rd(0, 2'd3, 32'h01, "edge_bit0");
    wr(2'd3, 32'h01);
    ci(0, 1'b0, "irq_clear_same_cycle");

    // Masked-off capture, then enabling the mask raises irq at once.
    wr(2'd2, 32'h00);
    in_port = 8'hAD;
    tick(4);
    rd(0, 2'd3, 32'h08, "edge_bit3");
    ci(0, 1'b0, "irq_masked_off");
    wr(2'd2, 32'h08);
    ci(0, 1'b1, "irq_mask_enable");

    // Clear of bit2 landing on the same edge as a new bit2 capture.
    wr(2'd3, 32'hFF);
    wr(2'd2, 32'h04);
    in_port = 8'hA9;
    tick(4);
    in_port = 8'hAD;
    tick(4);
    ci(0, 1'b1, "irq_bit2_set");
    in_port = 8'hA9;
    tick(4);
    in_port = 8'hAD;
    tick(2);
    wr(2'd3, 32'h04);
    ci(0, 1'b1, "irq_set_beats_clear");
    rd(0, 2'd3, 32'h04, "edge_set_beats_clear");

    // Edge type comparison on bit5: falling then rising.
    wr(2'd3, 32'hFF);
    in_port = 8'h8D;
    tick(4);
    rd(2, 2'd3, 32'h20, "any_on_fall");
    rd(1, 2'd3, 32'h20, "falling_on_fall");
    rd(0, 2'd3, 32'h00, "rising_on_fall");
    wr(2'd3, 32'hFF);
    in_port = 8'hAD;
    tick(4);
    rd(1, 2'd3, 32'h00, "falling_on_rise");
    rd(2, 2'd3, 32'h20, "any_on_rise");
    rd(0, 2'd3, 32'h20, "rising_on_rise");

    // Asynchronous reset while irq is high.
    wr(2'd2, 32'h20);
    ci(0, 1'b1, "irq_before_reset");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_irq", {31'b0, irq0}, 32'h0);
    check("async_readdata", rd0, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd(0, 2'd2, 32'h0, "mask_after_reset");
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'h0);
    rd(0, 2'd1, 32'h0, "dir_write_ignored");
    rd(0, 2'd0, 32'h0000_00AD, "data_write_ignored");
    ci(0, 1'b0, "irq_after_reset");
    rd(0, 2'd3, 32'h0000_00AD, "edge_high_through_reset");

    tick(3);
    if (rd_val_q.size() != 0 || ir_val_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d reads and %0d irq samples never observed",
               rd_val_q.size(), ir_val_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pio_input_edge_capture.md
# pio_input_edge_capture

Parametrised Avalon-MM input PIO for the Nios II system: samples a WIDTH-bit external input bus through a synchroniser and exposes it as a read-only data register. Adds per-bit edge capture, an interrupt mask and a level interrupt to the CPU. It replaces the single-bit, unsynchronised, read-only input PIO.

## Interface
- WIDTH, 8: input bus width, 1..32.
- EDGE_TYPE, 0: capture mode; 0 = rising, 1 = falling, 2 = any edge.
- SYNC_STAGES, 2: synchroniser depth, 2..4.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select, word address.
- chipselect  in  1  slave select, qualifies writes.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  external asynchronous inputs.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- irq  out  1  level interrupt to the CPU.

## Operation
- Register map:
  - 0 DATA: synchronised input, read-only.
  - 1 DIRECTION: reads 0, writes ignored.
  - 2 IRQ_MASK: read/write, WIDTH bits.
  - 3 EDGE_CAPTURE: read; write-1-to-clear.
- Synchroniser: each bit passes through SYNC_STAGES flops; its output is `sync`. A further flop holds `prev`, the previous value of `sync`.
- Edge detect, per bit:
  - Rising: sync & ~prev.
  - Falling: ~sync & prev.
  - Any: sync ^ prev.
- EDGE_CAPTURE bit: set on a detect and held until cleared by software.
- Write accepted when chipselect=1 and write_n=0. Only writedata[WIDTH-1:0] is used.
- Clear and new edge on the same bit in the same cycle: set wins, and the bit stays 1.
- irq = |(EDGE_CAPTURE & IRQ_MASK), driven combinationally from registers. It stays asserted until every masked captured bit is cleared.
- Read mux: readdata is loaded every clock from the register selected by address, with no read strobe. Upper bits are zero-filled.

## Timing
- Reset values: all synchroniser flops, prev, IRQ_MASK, EDGE_CAPTURE and readdata = 0. irq = 0.
- A change on in_port that is stable before clock edge k:
  - Appears on sync at edge k+SYNC_STAGES-1.
  - Sets the EDGE_CAPTURE bit and raises irq (if masked in) at edge k+SYNC_STAGES.
  - Is visible in DATA readdata at edge k+SYNC_STAGES.
- Read latency: readdata reflects the address and register state sampled at the previous clock edge. One cycle; the system integrates the slave with 0 wait states and readLatency 1.
- Write effect:
  - The register updates at the write edge.
  - irq deasserts in the same cycle the clear lands.
  - readdata shows the new value one edge later.
- Edges narrower than one clock are not guaranteed to be captured.
- A line held high through reset is seen as a rising edge (or any-edge) SYNC_STAGES+1 edges after reset release. Firmware clears EDGE_CAPTURE at init.
- Reset asserted mid-operation: all state clears immediately and irq drops asynchronously.

## Structure
- Shared package `pio_pkg`:
  - Address constants ADDR_DATA/ADDR_DIR/ADDR_MASK/ADDR_EDGE.
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings.
- One sub-module `pio_sync_edge`:
  - Parameters WIDTH, SYNC_STAGES, EDGE_TYPE.
  - Contains the synchroniser chain, the prev flop and the detect logic.
  - Outputs `sync` and a one-cycle `edge` pulse vector.
- The top level holds the registers, the read mux and irq.

## Test plan
All scenarios use WIDTH=8, EDGE_TYPE=0, SYNC_STAGES=2.
- Reset, then in_port=8'hA5 steady:
  - DATA reads 32'h000000A5.
  - After reset release, EDGE_CAPTURE reads 8'hA5.
  - Write 8'hFF to addr 3, then EDGE_CAPTURE reads 0.
- IRQ_MASK=8'h01, then in_port bit0 goes 0→1 at edge k:
  - EDGE_CAPTURE[0] and irq are 1 at edge k+2.
  - Write 1 to addr 3 bit0, and irq is 0 in the same cycle.
- IRQ_MASK=0, then bit3 rises:
  - EDGE_CAPTURE=8'h08.
  - irq stays 0.
  - Writing mask 8'h08 raises irq immediately.
- Clear of bit2 coincides with a new rising edge on bit2: EDGE_CAPTURE[2] remains 1 and irq stays high.
- EDGE_TYPE=2 rerun: toggling bit5 1→0 captures 8'h20. With EDGE_TYPE=1, a 0→1 transition does not capture.
- Assert reset_n mid-capture with irq=1:
  - irq, readdata and all registers go 0 asynchronously.
  - Writes to addr 0/1 have no effect.
